// File: rtl/stream_decompressor_pkg.sv
// Shared widths, tag codes and the tag-to-field-width helper for the stream decompressor.
package decomp_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_DATA   = 8;
  localparam int TAG_WIDTH  = 2;
  localparam int WORD_WIDTH = DATA_WIDTH * NUM_DATA;
  localparam int HDR_WIDTH  = TAG_WIDTH * NUM_DATA;
  localparam int MAX_BLOCK  = HDR_WIDTH + WORD_WIDTH;
  localparam int BUF_WIDTH  = 2 * WORD_WIDTH;
  localparam int FILL_W     = 10;
  localparam int LEN_W      = 9;

  localparam logic [TAG_WIDTH-1:0] TAG_ZERO = 2'b00;
  localparam logic [TAG_WIDTH-1:0] TAG_B8   = 2'b01;
  localparam logic [TAG_WIDTH-1:0] TAG_B16  = 2'b10;
  localparam logic [TAG_WIDTH-1:0] TAG_RAW  = 2'b11;

  typedef enum logic {ST_RUN, ST_DRAIN} state_t;

  function automatic logic [5:0] field_bits(input logic [TAG_WIDTH-1:0] tag);
    case (tag)
      TAG_ZERO: field_bits = 6'd0;
      TAG_B8:   field_bits = 6'd8;
      TAG_B16:  field_bits = 6'd16;
      default:  field_bits = 6'd32;
    endcase
  endfunction
endpackage

// File: rtl/stream_decompressor_if.sv
// Packed-stream input and decoded-block output handshakes of the decompressor.
interface stream_decompressor_if;
  import decomp_pkg::*;
  logic                  in_valid;
  logic                  in_ready;
  logic [WORD_WIDTH-1:0] in_data;
  logic                  in_last;
  logic [8:0]            in_bits;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  err;

  modport master (
    output in_valid, in_data, in_last, in_bits, out_ready,
    input  in_ready, out_valid, out_data, out_last, err
  );
  modport slave (
    input  in_valid, in_data, in_last, in_bits, out_ready,
    output in_ready, out_valid, out_data, out_last, err
  );
endinterface

// File: rtl/stream_decompressor_expander.sv
// Combinational block expander: decodes the block sitting at the bottom of the bit
// buffer into eight words and reports its total length in bits.
module block_expander
  import decomp_pkg::*;
(
  input  logic [MAX_BLOCK-1:0]                 blk,
  output logic [NUM_DATA-1:0][DATA_WIDTH-1:0]  words,
  output logic [LEN_W-1:0]                     len
);
  // off[i] is the bit position of payload field i; off[NUM_DATA] is the block length
  logic [NUM_DATA:0][LEN_W-1:0] off;

  always_comb begin
    off    = '0;
    off[0] = LEN_W'(HDR_WIDTH);
    for (int i = 0; i < NUM_DATA; i++)
      off[i+1] = off[i] + LEN_W'(field_bits(blk[TAG_WIDTH*i +: TAG_WIDTH]));
  end

  assign len = off[NUM_DATA];

  for (genvar i = 0; i < NUM_DATA; i++) begin : g_word
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] fld;
    assign tag = blk[TAG_WIDTH*i +: TAG_WIDTH];
    assign fld = blk[off[i] +: DATA_WIDTH];
    always_comb begin
      case (tag)
        TAG_ZERO: words[i] = '0;
        TAG_B8:   words[i] = {{(DATA_WIDTH-8){fld[7]}}, fld[7:0]};
        TAG_B16:  words[i] = {{(DATA_WIDTH-16){fld[15]}}, fld[15:0]};
        default:  words[i] = fld;
      endcase
    end
  end
endmodule

// File: rtl/stream_decompressor.sv
// Stream decompressor top: 512-bit bit buffer, fill counter, RUN/DRAIN FSM and output register.
// Optional framing-error reporting is enabled with `define DECOMP_ERR_CHECK_EN.
module stream_decompressor
  import decomp_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  stream_decompressor_if.slave  bus
);
  state_t                              state, state_nxt;
  logic [BUF_WIDTH-1:0]                bit_buf, buf_nxt, shifted, append;
  logic [FILL_W-1:0]                   fill, fill_nxt, base;
  logic [NUM_DATA-1:0][DATA_WIDTH-1:0] exp_words;
  logic [LEN_W-1:0]                    blk_len, word_bits;
  logic                                accept, decodable, fire, residue, last_blk;
  logic                                out_valid_q, out_last_q;
  logic [WORD_WIDTH-1:0]               out_data_q;

  block_expander u_expander (
    .blk   (bit_buf[MAX_BLOCK-1:0]),
    .words (exp_words),
    .len   (blk_len)
  );

  assign bus.in_ready = reset && (state == ST_RUN) && (fill <= FILL_W'(WORD_WIDTH));
  assign accept       = bus.in_valid && bus.in_ready;
  assign decodable    = (fill >= FILL_W'(HDR_WIDTH)) && (fill >= FILL_W'(blk_len));
  assign fire         = decodable && (!out_valid_q || bus.out_ready);

`ifdef DECOMP_ERR_CHECK_EN
  assign word_bits = (!bus.in_last || bus.in_bits == '0) ? LEN_W'(WORD_WIDTH) : bus.in_bits;
`else
  assign word_bits = bus.in_last ? bus.in_bits : LEN_W'(WORD_WIDTH);
`endif

  always_comb begin
    state_nxt = state;
    last_blk  = 1'b0;
    residue   = 1'b0;
    case (state)
      ST_RUN: if (accept && bus.in_last) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (fire && fill == FILL_W'(blk_len)) begin
          state_nxt = ST_RUN;
          last_blk  = 1'b1;
        end else if (!decodable) begin
          // Leftover bits too short to form a block: drop them and rearm
          state_nxt = ST_RUN;
          residue   = (fill != '0);
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Shift out the decoded block first, then append the new word at the reduced fill.
  // The new word is masked so buffer bits above fill always stay zero.
  always_comb begin
    shifted  = fire ? (bit_buf >> blk_len) : bit_buf;
    base     = fire ? (fill - FILL_W'(blk_len)) : fill;
    append   = ({{WORD_WIDTH{1'b0}}, bus.in_data} & ~({BUF_WIDTH{1'b1}} << word_bits)) << base;
    buf_nxt  = shifted;
    fill_nxt = base;
    if (accept) begin
      buf_nxt  = shifted | append;
      fill_nxt = base + FILL_W'(word_bits);
    end
    if (residue) begin
      buf_nxt  = '0;
      fill_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RUN;
      bit_buf     <= '0;
      fill        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_buf <= buf_nxt;
      fill    <= fill_nxt;
      if (fire) begin
        out_valid_q <= 1'b1;
        out_data_q  <= exp_words;
        out_last_q  <= last_blk;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;

`ifdef DECOMP_ERR_CHECK_EN
  logic err_q;
  // Sticky until the next stream's first word; a zero in_bits on that word re-flags it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_q <= 1'b0;
    else if (residue || (accept && bus.in_last && bus.in_bits == '0))
      err_q <= 1'b1;
    else if (accept)
      err_q <= 1'b0;
  end
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_stream_decompressor.sv
// Directed bench for stream_decompressor: table of single-block streams plus
// multi-block, backpressure, residue and mid-stream reset sequences.
module tb_stream_decompressor;
  import decomp_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  stream_decompressor_if bus();
  stream_decompressor dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef DECOMP_ERR_CHECK_EN
  localparam logic EXP_RES_ERR = 1'b1;
`else
  localparam logic EXP_RES_ERR = 1'b0;
`endif

  typedef struct {
    logic [15:0]          hdr;
    logic [7:0][31:0]     pay;
    logic [255:0]         exp;
  } vec_t;

  vec_t         vecs[5];
  int           checks = 0;
  int           errors = 0;
  bit           sbits[$];
  logic [255:0] got_d[$];
  logic         got_l[$];

  always @(negedge clk)
    if (reset && bus.out_valid && bus.out_ready) begin
      got_d.push_back(bus.out_data);
      got_l.push_back(bus.out_last);
    end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int b = 0; b < n; b++) sbits.push_back(v[b]);
  endtask

  task automatic pack_block(input vec_t v);
    push_bits({16'h0, v.hdr}, 16);
    for (int i = 0; i < 8; i++) begin
      logic [1:0] t;
      t = v.hdr[2*i +: 2];
      push_bits(v.pay[i], (t == 2'd0) ? 0 : (t == 2'd1) ? 8 : (t == 2'd2) ? 16 : 32);
    end
  endtask

  task automatic send_stream();
    while (sbits.size() > 0) begin
      logic [255:0] d;
      int n;
      int to;
      d  = '0;
      to = 0;
      n  = (sbits.size() > 256) ? 256 : sbits.size();
      for (int b = 0; b < n; b++) d[b] = sbits.pop_front();
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      bus.in_last  = (sbits.size() == 0);
      bus.in_bits  = 9'(n);
      @(negedge clk);
      while (!bus.in_ready && to < 2000) begin
        @(negedge clk);
        to++;
      end
      if (to >= 2000) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: in_ready stuck low, got 0 want 1");
      end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_outs(input int n, input string name);
    int to;
    to = 0;
    while (got_d.size() < n && to < 2000) begin
      @(posedge clk); #1;
      to++;
    end
    repeat (5) begin @(posedge clk); #1; end
    check({name, "_count"}, got_d.size(), n);
  endtask

  function automatic logic [255:0] got_at(input int i);
    return (i < got_d.size()) ? got_d[i] : 'x;
  endfunction

  function automatic logic last_at(input int i);
    return (i < got_l.size()) ? got_l[i] : 1'bx;
  endfunction

  initial begin : main
    int           order[6];
    int           nz, lastcnt;
    logic [255:0] snap;
    logic         stable, rdy_low;
    int           to;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b1;

    vecs[0].hdr = 16'hFFFF;
    vecs[0].pay = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    vecs[0].exp = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    vecs[1].hdr = 16'h5555;
    vecs[1].pay = {32'h7E, 32'h81, 32'h10, 32'h00, 32'hFF, 32'h01, 32'h7F, 32'h80};
    vecs[1].exp = {32'h0000007E, 32'hFFFFFF81, 32'h00000010, 32'h00000000,
                   32'hFFFFFFFF, 32'h00000001, 32'h0000007F, 32'hFFFFFF80};
    vecs[2].hdr = 16'h0000;
    vecs[2].pay = {8{32'hFFFFFFFF}};
    vecs[2].exp = '0;
    vecs[3].hdr = 16'hAAAA;
    vecs[3].pay = {32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF, 32'h1234, 32'h7FFF, 32'h8000};
    vecs[3].exp = {32'h0, 32'h0, 32'h0, 32'h0,
                   32'hFFFFFFFF, 32'h00001234, 32'h00007FFF, 32'hFFFF8000};
    vecs[4].hdr = 16'hE4E4;
    vecs[4].pay = {32'hCAFEF00D, 32'h8001, 32'h05, 32'h99, 32'hDEADBEEF, 32'h1234, 32'h85, 32'h77};
    vecs[4].exp = {32'hCAFEF00D, 32'hFFFF8001, 32'h00000005, 32'h00000000,
                   32'hDEADBEEF, 32'h00001234, 32'hFFFFFF85, 32'h00000000};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_err", bus.err, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("run_in_ready", bus.in_ready, 1);

    // Each table entry as its own single-block stream
    for (int i = 0; i < 5; i++) begin
      got_d.delete(); got_l.delete();
      pack_block(vecs[i]);
      send_stream();
      wait_outs(1, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_data", i), got_at(0), vecs[i].exp);
      check($sformatf("vec%0d_last", i), last_at(0), 1);
      check($sformatf("vec%0d_err", i), bus.err, 0);
    end

    // 32 zero-header blocks packed into two full words
    got_d.delete(); got_l.delete();
    for (int i = 0; i < 32; i++) push_bits(32'h0, 16);
    send_stream();
    wait_outs(32, "zeros");
    nz = 0; lastcnt = 0;
    for (int i = 0; i < got_d.size(); i++) begin
      if (got_d[i] !== '0) nz++;
      if (got_l[i] !== 1'b0) lastcnt++;
    end
    check("zeros_nonzero", nz, 0);
    check("zeros_last_count", lastcnt, 1);
    check("zeros_last_pos", last_at(31), 1);

    // Downstream stall of 10 cycles in the middle of a six-block stream
    got_d.delete(); got_l.delete();
    order = '{0, 1, 3, 4, 0, 1};
    for (int i = 0; i < 6; i++) pack_block(vecs[order[i]]);
    stable = 1'b1; rdy_low = 1'b0;
    fork
      send_stream();
      begin
        to = 0;
        while (got_d.size() < 1 && to < 2000) begin @(posedge clk); #1; to++; end
        bus.out_ready = 1'b0;
        @(negedge clk);
        snap = bus.out_data;
        repeat (10) begin
          if (bus.out_data !== snap || bus.out_valid !== 1'b1) stable = 1'b0;
          if (!bus.in_ready) rdy_low = 1'b1;
          @(negedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    check("stall_stable", stable, 1);
    check("stall_in_ready_drop", rdy_low, 1);
    wait_outs(6, "stall");
    for (int i = 0; i < 6; i++)
      check($sformatf("stall_blk%0d", i), got_at(i), vecs[order[i]].exp);
    check("stall_last", {got_l.size() == 6 ? got_l[0] | got_l[1] | got_l[2] | got_l[3] | got_l[4] : 1'bx, last_at(5)}, 2'b01);

    // 80-bit block followed by 8 leftover bits
    got_d.delete(); got_l.delete();
    pack_block(vecs[1]);
    push_bits(32'h0, 8);
    send_stream();
    wait_outs(1, "residue");
    check("residue_data", got_at(0), vecs[1].exp);
    check("residue_last", last_at(0), 0);
    check("residue_err", bus.err, EXP_RES_ERR);
    check("residue_fill", dut.fill, 0);
    check("residue_in_ready", bus.in_ready, 1);

    // Reset in the middle of a two-word block
    got_d.delete(); got_l.delete();
    pack_block(vecs[0]);
    bus.in_data = '0;
    for (int b = 0; b < 256; b++) bus.in_data[b] = sbits.pop_front();
    sbits.delete();
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("err_clear_on_accept", bus.err, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_out_last", bus.out_last, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_fill", dut.fill, 0);
    @(posedge clk); #3;
    reset = 1'b1;
    @(posedge clk); #1;
    pack_block(vecs[4]);
    send_stream();
    wait_outs(1, "post_rst");
    check("post_rst_data", got_at(0), vecs[4].exp);
    check("post_rst_last", last_at(0), 1);
    check("post_rst_err", bus.err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stream_decompressor.md
# stream_decompressor

Receive-side counterpart of the compression pipeline. Accepts the packed 256-bit stream that the aligner produces: contiguous variable-length blocks, each a 16-bit tag header followed by 8 compressed payload fields. Unpacks the blocks across word boundaries, expands each block back to eight 32-bit words, and emits one 256-bit word per block over a valid/ready handshake.

## Interface
- DATA_WIDTH, 32, width of one uncompressed data word
- NUM_DATA, 8, words per block
- TAG_WIDTH, 2, tag bits per word
- WORD_WIDTH, 256, stream word width (DATA_WIDTH*NUM_DATA)
- clk  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  stream word valid
- in_ready  out  1  stream word accepted when in_valid && in_ready
- in_data  in  WORD_WIDTH  packed stream, LSB-first bit order
- in_last  in  1  final word of a stream
- in_bits  in  9  valid bits in the in_last word, 1..256; ignored otherwise (256 implied)
- out_valid  out  1  decoded block valid
- out_ready  in  1  downstream accepts the block
- out_data  out  WORD_WIDTH  word i at bits [32i+31:32i]
- out_last  out  1  last block of the stream
- err  out  1  stream framing error (see Configuration)

## Operation
- Block format: header bits [15:0]; tag i at header[2i+1:2i]. Payload fields follow in order i=0..7.
- Tag encoding:
  - 00: word = 0, 0 payload bits
  - 01: 8-bit payload, sign-extended
  - 10: 16-bit payload, sign-extended
  - 11: 32-bit raw
- Block length: len = 16 + sum(field bits). Range 16..272.
- Bit buffer: 512 bits, with fill count `fill` (10 bits, 0..512). A new word is appended at bit position `fill`.
- Accept rule: in_ready = (state==RUN) && (fill <= 256) && reset high.
- Decode rule: a block is decodable when fill >= 16 and fill >= len(header at buffer[15:0]).
- Decode fires when the block is decodable and (!out_valid || out_ready).
  - On fire: buffer shifts right by len, fill -= len, and the output register loads.
- Simultaneous accept and decode on the same edge: shift first, then append at (fill - len). New fill = fill - len + bits.
- State machine:
  - RUN → DRAIN when a word with in_last is accepted.
  - DRAIN: no input accepted; blocks keep decoding.
  - DRAIN → RUN when fill reaches 0 via a decode, with out_last=1 loaded on that block.
  - DRAIN → RUN also when fill > 0 but no block is decodable (residue). This sets err; the residue is discarded and fill is cleared to 0.
- Reset mid-stream: buffer contents are lost, fill=0, state=RUN. No partial output is produced.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, err=0
  - fill=0, state=RUN
  - in_ready=0 while reset is low

## Timing
- Input-to-output latency: a block completed by the word accepted on edge N loads out_valid on edge N+1.
- Throughput: one block per cycle while decodable and downstream is ready. Input rate is at most one word per cycle.
- out_data and out_last are held stable while out_valid && !out_ready.
- The fill ≤ 256 accept threshold guarantees no buffer overflow, including the worst case of a 272-bit block with no decode.

## Configuration
- DECOMP_ERR_CHECK_EN defined:
  - err is driven as described and is sticky until the first word of the next stream is accepted.
  - in_bits of 0 on an in_last word also sets err; the word is treated as 256 bits.
- DECOMP_ERR_CHECK_EN undefined:
  - err is tied to 0.
  - Residue is discarded silently, and in_bits is used unchecked.

## Structure
- Package decomp_pkg holds:
  - the width constants
  - tag constants TAG_ZERO, TAG_B8, TAG_B16, TAG_RAW
  - a function field_bits(tag) returning 0, 8, 16 or 32
- Sub-module block_expander (combinational):
  - input: low 272 buffer bits
  - outputs: 256-bit expanded words and a 9-bit len
- The top level holds the bit buffer, fill counter, FSM and output register.

## Test plan
- Single block, header 0xFFFF plus words 0..7 = 0x1..0x8 (272 bits over 2 words, in_last, in_bits=16) → one output 0x8..0x1 with out_last=1, err=0.
- Header 0x5555 with payloads 0x80,0x7F,… (80-bit block, in_last, in_bits=80) → word0=0xFFFFFF80, word1=0x0000007F, out_last=1.
- 32 consecutive all-zero headers (16 bits each = 2 words) → 32 blocks of all-zero output; last has out_last=1.
- out_ready held low 10 cycles mid-stream → out_data stable, in_ready drops once fill > 256, no block lost or duplicated.
- Stream ending with 8 residual bits (in_bits=88 after an 80-bit block) → the block is output, then err=1 (check enabled) / err=0 (disabled), fill returns to 0.
- Reset asserted mid-block → all outputs 0 immediately. After release, a fresh stream decodes correctly.
